// File: rtl/serial_word_collector_if.sv
// Stream bundle between a serial bit producer, the word collector and the word consumer.
interface serial_word_collector_if #(
    parameter int WIDTH = 8
) ();
    logic                     inBit;
    logic                     inValid;
    logic                     inReady;
    logic [WIDTH-1:0]         outBits;
    logic                     outValid;
    logic                     outReady;
    logic [$clog2(WIDTH)-1:0] bitCount;

    // Producer/consumer side: drives bits in and takes words out.
    modport master (
        output inBit, inValid, outReady,
        input  inReady, outBits, outValid, bitCount
    );

    // Collector side.
    modport slave (
        input  inBit, inValid, outReady,
        output inReady, outBits, outValid, bitCount
    );
endinterface

// File: rtl/serial_word_collector.sv
// Serial-to-parallel word collector with a one-word holding register and
// a valid/ready handshake on both sides.
module serial_word_collector #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   io_clock,
    input  logic                   io_resetNegate,
    input  logic                   io_clear,
    serial_word_collector_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] nextSr;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             lastBit;
    logic             inReady;
    logic             accept;

    // The final bit stalls while a word is still held; decided from registered
    // state only, so outReady never reaches inReady combinationally.
    assign lastBit = (cnt == CW'(WIDTH - 1));
    assign inReady = !(lastBit && full);
    assign accept  = bus.inValid && inReady;

    // Shift the incoming bit into the partial word in the configured order.
    always_comb begin
        nextSr = sr;
        if (MSB_FIRST) begin
            nextSr = {sr[WIDTH-2:0], bus.inBit};
        end else begin
            nextSr = {bus.inBit, sr[WIDTH-1:1]};
        end
    end

    // Partial word, bit counter, holding register and its valid flag.
    always_ff @(posedge io_clock or negedge io_resetNegate) begin
        if (!io_resetNegate) begin
            sr   <= '0;
            cnt  <= '0;
            hold <= '0;
            full <= 1'b0;
        end else if (io_clear) begin
            sr   <= '0;
            cnt  <= '0;
            hold <= '0;
            full <= 1'b0;
        end else begin
            if (full && bus.outReady) begin
                full <= 1'b0;
            end
            // A final-bit accept implies full is 0, so it never races the take above.
            if (accept) begin
                if (lastBit) begin
                    hold <= nextSr;
                    full <= 1'b1;
                    cnt  <= '0;
                    sr   <= '0;
                end else begin
                    sr  <= nextSr;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign bus.inReady  = inReady;
    assign bus.outBits  = hold;
    assign bus.outValid = full;
    assign bus.bitCount = cnt;
endmodule

// File: tb/tb_serial_word_collector.sv
// Randomized and directed bench for serial_word_collector; an MSB-first and an
// LSB-first instance see identical stimulus and are checked against a bit-queue model.
module tb_serial_word_collector;
    localparam int W = 8;

    logic clk;
    logic rstN;
    logic clr;
    logic tbBit;
    logic tbValid;
    logic tbOutReady;

    int nCompared;
    int nMismatched;

    // Reference model: bits of the partial word in arrival order, plus the held word.
    int         mBits[$];
    logic       mFull;
    logic [W-1:0] mHoldM;
    logic [W-1:0] mHoldL;

    serial_word_collector_if #(.WIDTH(W)) busM ();
    serial_word_collector_if #(.WIDTH(W)) busL ();

    assign busM.inBit    = tbBit;
    assign busM.inValid  = tbValid;
    assign busM.outReady = tbOutReady;
    assign busL.inBit    = tbBit;
    assign busL.inValid  = tbValid;
    assign busL.outReady = tbOutReady;

    serial_word_collector #(.WIDTH(W), .MSB_FIRST(1'b1)) dutM (
        .io_clock       (clk),
        .io_resetNegate (rstN),
        .io_clear       (clr),
        .bus            (busM.slave)
    );

    serial_word_collector #(.WIDTH(W), .MSB_FIRST(1'b0)) dutL (
        .io_clock       (clk),
        .io_resetNegate (rstN),
        .io_clear       (clr),
        .bus            (busL.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] packWord(input bit msbFirst);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < mBits.size(); i++) begin
            if (mBits[i] != 0) begin
                if (msbFirst) v[W-1-i] = 1'b1;
                else          v[i]     = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic modelReady();
        return !(mBits.size() == W - 1 && mFull);
    endfunction

    task automatic modelClear();
        mBits.delete();
        mFull  = 1'b0;
        mHoldM = '0;
        mHoldL = '0;
    endtask

    task automatic checkAll();
        chk("inReadyM",  {31'd0, busM.inReady},  {31'd0, modelReady()});
        chk("inReadyL",  {31'd0, busL.inReady},  {31'd0, modelReady()});
        chk("outValidM", {31'd0, busM.outValid}, {31'd0, mFull});
        chk("outValidL", {31'd0, busL.outValid}, {31'd0, mFull});
        chk("outBitsM",  32'(busM.outBits),      32'(mHoldM));
        chk("outBitsL",  32'(busL.outBits),      32'(mHoldL));
        chk("bitCountM", 32'(busM.bitCount),     32'(mBits.size()));
        chk("bitCountL", 32'(busL.bitCount),     32'(mBits.size()));
    endtask

    // One clock cycle: drive inputs, check current outputs, then advance the model
    // to what the coming rising edge should produce.
    task automatic cyc(input logic c, input logic v, input logic b, input logic r);
        logic rdy;
        @(negedge clk);
        clr        = c;
        tbValid    = v;
        tbBit      = b;
        tbOutReady = r;
        #1;
        checkAll();
        if (c) begin
            modelClear();
        end else begin
            rdy = modelReady();
            if (mFull && r) mFull = 1'b0;
            if (v && rdy) begin
                mBits.push_back(int'(b));
                if (mBits.size() == W) begin
                    mHoldM = packWord(1'b1);
                    mHoldL = packWord(1'b0);
                    mFull  = 1'b1;
                    mBits.delete();
                end
            end
        end
    endtask

    task automatic sendByte(input logic [W-1:0] v, input logic r);
        for (int i = W - 1; i >= 0; i--) cyc(1'b0, 1'b1, v[i], r);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic asyncReset();
        @(negedge clk);
        clr        = 1'b0;
        tbValid    = 1'b0;
        tbOutReady = 1'b0;
        #2;
        rstN = 1'b0;
        #1;
        modelClear();
        checkAll();
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rstN        = 1'b0;
        clr         = 1'b0;
        tbBit       = 1'b0;
        tbValid     = 1'b0;
        tbOutReady  = 1'b0;
        modelClear();
        #12;
        checkAll();
        @(negedge clk);
        rstN = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Bit order: 1,1,0,0,0,0,0,0 -> 0xC0 MSB-first, 0x03 LSB-first.
        sendByte(8'b1100_0000, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("orderMsb", 32'(busM.outBits), 32'h0000_00C0);
        chk("orderLsb", 32'(busL.outBits), 32'h0000_0003);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure: stream ones with the consumer stalled, then take once.
        for (int i = 0; i < 18; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("bpStall", {31'd0, busM.inReady}, 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("bpSecond", 32'(busM.outBits), 32'h0000_00FF);

        // Async reset mid-word with a word held, then collect 0xA5.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        asyncReset();
        sendByte(8'hA5, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("afterReset", 32'(busM.outBits), 32'h0000_00A5);

        // Clear with a bit offered at bitCount 3.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("clearCount", 32'(busM.bitCount), 32'd0);

        // Concurrent take and non-final bit at bitCount 2.
        sendByte(8'h3C, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("takeValid", {31'd0, busM.outValid}, 32'd0);
        chk("takeCount", 32'(busM.bitCount), 32'd3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 499) == 0) asyncReset();
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/serial_word_collector.md
# serial_word_collector

Collects the serial bit stream produced by the team's flip-flop/latch stages into WIDTH-bit parallel words and presents them over a valid/ready handshake. It sits directly downstream of the synchronous-reset flip-flop stage and consumes one registered bit per accepted cycle. A one-word holding register lets the next word shift in while the consumer is still busy with the previous one.

## Interface
Parameters:
- WIDTH, 8, word length in bits; legal range 2 to 32.
- MSB_FIRST, 1, bit order: 1 means the first received bit lands in bit WIDTH-1; 0 means it lands in bit 0.

Ports:
- io_clock  input  1  sole clock; all state updates on its rising edge.
- io_resetNegate  input  1  asynchronous, active-low reset.
- io_clear  input  1  synchronous clear; discards the partial word and the held word.
- io_inBit  input  1  serial data bit.
- io_inValid  input  1  io_inBit is valid this cycle.
- io_inReady  output  1  collector can accept a bit this cycle.
- io_outBits  output  WIDTH  completed word.
- io_outValid  output  1  io_outBits holds an unconsumed word.
- io_outReady  input  1  consumer takes the word this cycle.
- io_bitCount  output  clog2(WIDTH)  number of bits in the partial word, 0 to WIDTH-1.

## Operation
- State:
  - shift register sr (WIDTH bits)
  - counter cnt (clog2(WIDTH) bits)
  - holding register hold (WIDTH bits)
  - flag full, which drives io_outValid
- Bit accept: a bit is accepted when io_inValid and io_inReady are both 1.
- Shift rule for each accepted bit:
  - MSB_FIRST=1: next = {sr[WIDTH-2:0], io_inBit}.
  - MSB_FIRST=0: next = {io_inBit, sr[WIDTH-1:1]}.
- Accepted bit with cnt < WIDTH-1: sr <= next; cnt <= cnt+1.
- Accepted bit with cnt == WIDTH-1: hold <= next; full <= 1; cnt <= 0; sr <= 0.
- Output handshake: when io_outValid and io_outReady are both 1, full <= 0 at the next edge. hold keeps its value; it is simply no longer valid.
- io_inReady = !(cnt == WIDTH-1 && full).
  - This is decided purely from registered state. There is no combinational path from io_outReady to io_inReady.
  - Consequence: the final bit of a word waits while the previous word is unconsumed. It also waits for one cycle if the consumer takes the held word in that same cycle.
- Simultaneous output take and final-bit acceptance cannot occur, because io_inReady is 0 whenever full is 1 and cnt == WIDTH-1.
- Output take and non-final bit acceptance in the same cycle: both take effect independently.
- io_clear=1 has priority over all other activity. At the next edge: sr=0, cnt=0, full=0, and hold=0. Bits offered during a clear cycle are discarded, even if io_inReady is 1.
- io_outBits = hold. io_outBits and io_outValid are registered outputs.
- io_bitCount = cnt.

## Timing
- Reset (io_resetNegate=0): takes effect immediately, without waiting for a clock edge.
  - sr=0, cnt=0, hold=0, full=0.
  - Resulting outputs: io_outValid=0, io_outBits=0, io_bitCount=0, io_inReady=1.
- Reset asserted mid-word or with a word held: all partial and held data is lost. Collection restarts at bit 0 on the first edge after deassertion.
- Latency: the final bit is accepted at edge N; io_outValid=1 and io_outBits are valid from edge N through the cycle until edge N+1.
- Throughput: one bit per cycle sustained, provided the consumer takes each word within WIDTH-1 cycles of io_outValid rising.
- Producer rule: io_inBit must hold its value while io_inValid=1 and io_inReady=0.
- Consumer rule: io_outBits is stable while io_outValid=1 and the word has not been taken.
- io_bitCount wraps from WIDTH-1 to 0 only on acceptance of the final bit.

## Test plan
- MSB order: WIDTH=8, MSB_FIRST=1, send bits 1,1,0,0,0,0,0,0 on consecutive cycles with io_outReady=1 -> io_outValid=1 with io_outBits=0xC0 one cycle after the 8th bit; io_bitCount reads 0..7 then 0.
- LSB order: repeat the same bit sequence with MSB_FIRST=0 -> io_outBits=0x03.
- Backpressure: hold io_outReady=0 and stream 1 continuously -> first word 0xFF held; io_inReady drops to 0 when io_bitCount=7; the 16th bit stalls. Raise io_outReady for one cycle -> io_outValid deasserts, io_inReady returns to 1 on the following cycle, the 16th bit is accepted, and a second word 0xFF appears.
- Async reset: assert io_resetNegate=0 between clock edges after 5 bits, with a word held -> io_outValid, io_bitCount and io_outBits read 0 immediately. After release, 8 new bits 10100101 -> 0xA5.
- Clear with bit offered: at io_bitCount=3, drive io_clear=1 together with io_inValid=1 -> next cycle io_bitCount=0 and io_outValid=0; the offered bit is not counted.
- Concurrent take: with a held word and io_bitCount=2, drive io_outReady=1 and io_inValid=1 in the same cycle -> next cycle io_outValid=0 and io_bitCount=3.
